// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor: one carry-chained slice per register stage,
// valid/ready on both sides, global stall when the output is held.
module pipelined_add_sub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic [TAG_W-1:0] OutTag
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a multiple of STAGES");
    end

    logic              adv;
    logic [STAGES:1]   vld_pipe;
    logic              last_vld;

    assign adv      = !OutValid || OutReady;
    assign InReady  = !Reset && adv;
    assign OutValid = vld_pipe[STAGES];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= InValid;
            for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    if (STAGES == 1) begin : g_lv1
        assign last_vld = InValid;
    end else begin : g_lvn
        assign last_vld = vld_pipe[STAGES-1];
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Only the operand bits not yet summed travel down the pipe.
        localparam int AW = WIDTH - k * SLICE;

        logic [AW-1:0]          a_in;
        logic [AW-1:0]          b_in;
        logic                   c_in;
        logic                   sub_in;
        logic [TAG_W-1:0]       tag_in;
        logic [SLICE:0]         slice_sum;
        logic [(k+1)*SLICE-1:0] s_nxt;

        if (k == 0) begin : g_src
            assign a_in   = A;
            assign b_in   = B ^ {WIDTH{Sub}};
            assign c_in   = Cin ^ Sub;
            assign sub_in = Sub;
            assign tag_in = InTag;
            assign s_nxt  = slice_sum[SLICE-1:0];
        end else begin : g_src
            assign a_in   = stg[k-1].g_reg.a_q;
            assign b_in   = stg[k-1].g_reg.b_q;
            assign c_in   = stg[k-1].g_reg.c_q;
            assign sub_in = stg[k-1].g_reg.sub_q;
            assign tag_in = stg[k-1].g_reg.tag_q;
            assign s_nxt  = {slice_sum[SLICE-1:0], stg[k-1].g_reg.s_q};
        end

        assign slice_sum = {1'b0, a_in[SLICE-1:0]} + {1'b0, b_in[SLICE-1:0]}
                         + {{SLICE{1'b0}}, c_in};

        if (k < LAST) begin : g_reg
            logic [AW-SLICE-1:0]    a_q;
            logic [AW-SLICE-1:0]    b_q;
            logic [(k+1)*SLICE-1:0] s_q;
            logic                   c_q;
            logic                   sub_q;
            logic [TAG_W-1:0]       tag_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    s_q   <= '0;
                    c_q   <= 1'b0;
                    sub_q <= 1'b0;
                    tag_q <= '0;
                end else if (adv) begin
                    a_q   <= a_in[AW-1:SLICE];
                    b_q   <= b_in[AW-1:SLICE];
                    s_q   <= s_nxt;
                    c_q   <= slice_sum[SLICE];
                    sub_q <= sub_in;
                    tag_q <= tag_in;
                end
            end
        end
    end

    // Carry into the MSB recovered from the MSB sum bit of the final slice.
    logic msb_cin;
    logic fin_carry;
    assign msb_cin   = stg[LAST].a_in[SLICE-1] ^ stg[LAST].b_in[SLICE-1]
                     ^ stg[LAST].slice_sum[SLICE-1];
    assign fin_carry = stg[LAST].slice_sum[SLICE];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            OutTag   <= '0;
        end else if (adv && last_vld) begin
            Result   <= stg[LAST].s_nxt;
            Cout     <= fin_carry ^ stg[LAST].sub_in;
            Overflow <= msb_cin ^ fin_carry;
            Zero     <= (stg[LAST].s_nxt == '0);
            Negative <= stg[LAST].s_nxt[WIDTH-1];
            OutTag   <= stg[LAST].tag_in;
        end
    end
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three configurations (16/4, 32/8, 8/1) driven in lockstep,
// each checked against an arithmetic reference model through an in-order scoreboard.
module tb_pipelined_add_sub;
    logic        Clk = 1'b0;
    logic        rst, in_vld, out_rdy, cin, sub;
    logic [31:0] a, b;
    logic [3:0]  tag;

    logic        ir16, ov16, co16, of16, z16, n16;
    logic [15:0] r16;
    logic [3:0]  t16;
    logic        ir32, ov32, co32, of32, z32, n32;
    logic [31:0] r32;
    logic [3:0]  t32;
    logic        ir8, ov8, co8, of8, z8, n8;
    logic [7:0]  r8;
    logic [3:0]  t8;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] res;
        logic        cout, ovf, zero, neg;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[3][$];

    always #5 Clk = ~Clk;

    pipelined_add_sub #(.WIDTH(16), .STAGES(4), .TAG_W(4)) dut16 (
        .Clk(Clk), .Reset(rst), .InValid(in_vld), .InReady(ir16), .A(a[15:0]), .B(b[15:0]),
        .Cin(cin), .Sub(sub), .InTag(tag), .OutValid(ov16), .OutReady(out_rdy), .Result(r16),
        .Cout(co16), .Overflow(of16), .Zero(z16), .Negative(n16), .OutTag(t16));

    pipelined_add_sub #(.WIDTH(32), .STAGES(8), .TAG_W(4)) dut32 (
        .Clk(Clk), .Reset(rst), .InValid(in_vld), .InReady(ir32), .A(a), .B(b),
        .Cin(cin), .Sub(sub), .InTag(tag), .OutValid(ov32), .OutReady(out_rdy), .Result(r32),
        .Cout(co32), .Overflow(of32), .Zero(z32), .Negative(n32), .OutTag(t32));

    pipelined_add_sub #(.WIDTH(8), .STAGES(1), .TAG_W(4)) dut8 (
        .Clk(Clk), .Reset(rst), .InValid(in_vld), .InReady(ir8), .A(a[7:0]), .B(b[7:0]),
        .Cin(cin), .Sub(sub), .InTag(tag), .OutValid(ov8), .OutReady(out_rdy), .Result(r8),
        .Cout(co8), .Overflow(of8), .Zero(z8), .Negative(n8), .OutTag(t8));

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic at width w, signed range test for overflow.
    function automatic exp_t model(input int w, input logic [31:0] aa, input logic [31:0] bb,
                                   input logic c, input logic s, input logic [3:0] tg);
        exp_t   e;
        longint m    = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(aa) & m;
        longint ub   = longint'(bb) & m;
        longint sa   = (ua >= half) ? ua - (m + 1) : ua;
        longint sb   = (ub >= half) ? ub - (m + 1) : ub;
        longint ci   = c ? 1 : 0;
        longint full, sf;
        if (!s) begin
            full   = ua + ub + ci;
            e.cout = (full > m);
            sf     = sa + sb + ci;
        end else begin
            full   = ua - ub - ci;
            e.cout = (full < 0);
            sf     = sa - sb - ci;
        end
        e.res  = 32'(full & m);
        e.ovf  = (sf >= half) || (sf < -half);
        e.zero = (e.res == 32'd0);
        e.neg  = e.res[w-1];
        e.tag  = tg;
        return e;
    endfunction

    task automatic sb(input int d, input int w, input logic irdy, input logic ovld,
                      input logic [31:0] res, input logic co, input logic ov,
                      input logic z, input logic ng, input logic [3:0] tg);
        exp_t e;
        if (rst) begin
            q[d].delete();
        end else begin
            if (ovld && out_rdy) begin
                chk($sformatf("pending%0d", w), q[d].size() > 0, 1);
                if (q[d].size() > 0) begin
                    e = q[d].pop_front();
                    chk($sformatf("res%0d", w), res, e.res);
                    chk($sformatf("cout%0d", w), co, e.cout);
                    chk($sformatf("ovf%0d", w), ov, e.ovf);
                    chk($sformatf("zero%0d", w), z, e.zero);
                    chk($sformatf("neg%0d", w), ng, e.neg);
                    chk($sformatf("tag%0d", w), tg, e.tag);
                end
            end
            if (in_vld && irdy) q[d].push_back(model(w, a, b, cin, sub, tag));
        end
    endtask

    always @(negedge Clk) begin
        sb(0, 16, ir16, ov16, {16'h0, r16}, co16, of16, z16, n16, t16);
        sb(1, 32, ir32, ov32, r32, co32, of32, z32, n32, t32);
        sb(2, 8, ir8, ov8, {24'h0, r8}, co8, of8, z8, n8, t8);
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic rnd();
        a   = $urandom;
        b   = $urandom;
        if ($urandom_range(0, 7) == 0) b = a;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        tag = 4'($urandom_range(0, 15));
    endtask

    // One op into the 16-bit pipe; returns at the negedge where its result is presented.
    task automatic run16(input logic [31:0] aa, input logic [31:0] bb, input logic c,
                         input logic s);
        bit seen = 0;
        a = aa; b = bb; cin = c; sub = s; tag = 4'($urandom_range(0, 15)); in_vld = 1;
        step();
        in_vld = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            if (ov16) begin
                seen = 1;
                break;
            end
            step();
        end
        chk("run16_timeout", seen, 1);
    endtask

    logic [15:0] hold_r;
    logic [3:0]  hold_t;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a concurrent valid input, which must be dropped.
        rst = 1; in_vld = 1; out_rdy = 1; a = 32'h1234; b = 32'h1; cin = 0; sub = 0; tag = 4'hA;
        @(negedge Clk);
        chk("inrdy_rst16", ir16, 0);
        chk("inrdy_rst32", ir32, 0);
        chk("inrdy_rst8", ir8, 0);
        step();
        step();
        rst = 0;
        a = 32'h0000_FFFF; b = 32'h1; cin = 0; sub = 0; tag = 4'h5; in_vld = 1;
        @(negedge Clk);
        chk("rst_ov16", ov16, 0);
        chk("rst_res16", r16, 0);
        chk("rst_flags16", {co16, of16, z16, n16}, 0);
        chk("rst_tag16", t16, 0);
        chk("rst_ov32", ov32, 0);
        chk("rst_ov8", ov8, 0);
        chk("inrdy16", ir16, 1);

        // Latency per configuration.
        for (int c = 1; c <= 9; c++) begin
            step();
            if (c == 1) in_vld = 0;
            @(negedge Clk);
            chk($sformatf("lat16_c%0d", c), ov16, c == 4);
            chk($sformatf("lat32_c%0d", c), ov32, c == 8);
            chk($sformatf("lat8_c%0d", c), ov8, c == 1);
            if (c == 4) begin
                chk("wrap_res", r16, 16'h0000);
                chk("wrap_cout", co16, 1);
                chk("wrap_zero", z16, 1);
                chk("wrap_ovf", of16, 0);
                chk("wrap_tag", t16, 4'h5);
            end
        end
        step();

        run16(32'h7FFF, 32'h0001, 0, 0);
        chk("sovf_res", r16, 16'h8000);
        chk("sovf_ovf", of16, 1);
        chk("sovf_neg", n16, 1);
        chk("sovf_cout", co16, 0);
        step();
        run16(32'h0005, 32'h0007, 0, 1);
        chk("sub_res", r16, 16'hFFFE);
        chk("sub_cout", co16, 1);
        chk("sub_neg", n16, 1);
        step();
        run16(32'h1234, 32'h1234, 1, 1);
        chk("borrow_res", r16, 16'hFFFF);
        chk("borrow_cout", co16, 1);
        step();
        repeat (12) step();

        // Back-to-back random stream.
        for (int i = 0; i < 64; i++) begin
            rnd();
            in_vld = 1;
            @(negedge Clk);
            if (i >= 4) chk("tput16", ov16, 1);
            step();
        end
        in_vld = 0;
        repeat (12) step();

        // Global stall with the pipe full.
        for (int i = 0; i < 10; i++) begin
            rnd();
            in_vld = 1;
            step();
        end
        out_rdy = 0;
        rnd();
        for (int s = 0; s < 5; s++) begin
            @(negedge Clk);
            chk("stall_inrdy16", ir16, 0);
            chk("stall_inrdy32", ir32, 0);
            chk("stall_inrdy8", ir8, 0);
            chk("stall_ov16", ov16, 1);
            if (s == 0) begin
                hold_r = r16;
                hold_t = t16;
            end else begin
                chk("stall_res16", r16, hold_r);
                chk("stall_tag16", t16, hold_t);
            end
            step();
            rnd();
        end
        out_rdy = 1;
        for (int i = 0; i < 6; i++) begin
            rnd();
            step();
        end
        in_vld = 0;
        repeat (12) step();
        chk("stall_drain16", q[0].size(), 0);
        chk("stall_drain32", q[1].size(), 0);

        // Reset with three ops in flight.
        for (int i = 0; i < 3; i++) begin
            rnd();
            in_vld = 1;
            step();
        end
        in_vld = 0;
        rst = 1;
        step();
        rst = 0;
        @(negedge Clk);
        chk("midrst_ov16", ov16, 0);
        chk("midrst_ov32", ov32, 0);
        chk("midrst_ov8", ov8, 0);
        step();
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            chk("midrst_ghost16", ov16, 0);
            step();
        end

        // OutReady toggling every cycle with sparse input.
        for (int i = 0; i < 40; i++) begin
            rnd();
            in_vld  = ($urandom_range(0, 3) != 0);
            out_rdy = (i % 2 == 1);
            step();
        end
        in_vld = 0;
        out_rdy = 1;
        repeat (14) step();
        chk("toggle_drain16", q[0].size(), 0);
        chk("toggle_drain32", q[1].size(), 0);
        chk("toggle_drain8", q[2].size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
